// File: rtl/nopipe_mac_pkg.sv
// Shared definitions for the non-pipelined Q8.8 multiply-accumulate unit:
// command codes, FSM state encoding and Q8.8 range limits.
package nopipe_mac_pkg;

  // Command codes presented on wrAddr; codes 3..15 are no-ops.
  localparam logic [3:0] CMD_IDLE = 4'd0;
  localparam logic [3:0] CMD_LOAD = 4'd1;
  localparam logic [3:0] CMD_CLR  = 4'd2;

  // One operation in flight: capture operands, multiply, accumulate.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  // Q8.8 limits and fraction width.
  localparam logic [15:0] Q_MAX     = 16'h7FFF;
  localparam logic [15:0] Q_MIN     = 16'h8000;
  localparam int          FRAC_BITS = 8;

endpackage : nopipe_mac_pkg

// File: rtl/nopipe_mac_q88_sat_add.sv
// Combinational signed add, clamped to the Q8.8 range. Inputs are wide
// enough to carry a rescaled Q16.16 product, so the same block serves both
// for product rescale-saturation (b_i = 0) and for accumulation.
module q88_sat_add
  import nopipe_mac_pkg::*;
(
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic        [15:0] sum_o
);

  logic signed [32:0] sum_full;

  // Full-precision sum, then clamp anything outside [-128.0, +127.996].
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    sum_full = $signed({a_i[31], a_i}) + $signed({b_i[31], b_i});
    if (sum_full > 33'sd32767) begin
      sum_o = Q_MAX;
    end else if (sum_full < -33'sd32768) begin
      sum_o = Q_MIN;
    end else begin
      sum_o = sum_full[15:0];
    end
  end

endmodule : q88_sat_add

// File: rtl/nopipe_mac.sv
// Non-pipelined signed Q8.8 multiply-accumulate. One operand pair at a time
// goes IDLE -> MUL -> ACC; result mirrors the saturating accumulator.
module nopipe_mac
  import nopipe_mac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  wrAddr,
  output logic [15:0] result
);

  state_e             state_q, state_d;
  logic signed [15:0] op_a_q, op_a_d;
  logic signed [15:0] op_b_q, op_b_d;
  logic signed [31:0] prod_q, prod_d;
  logic        [15:0] acc_q, acc_d;

  logic signed [31:0] prod_full;
  logic signed [31:0] prod_shift;
  logic        [15:0] prod_q88;
  logic signed [31:0] acc_ext;
  logic signed [31:0] prod_q88_ext;
  logic        [15:0] acc_sum;

  // Single-cycle signed multiply (Q16.16) and its rescale to Q8.8; the
  // arithmetic shift keeps the sign so bits [31:23] decide saturation.
  assign prod_full    = op_a_q * op_b_q;
  assign prod_shift   = prod_q >>> FRAC_BITS;
  assign acc_ext      = {{16{acc_q[15]}}, acc_q};
  assign prod_q88_ext = {{16{prod_q88[15]}}, prod_q88};

  q88_sat_add u_rescale (
    .a_i   (prod_shift),
    .b_i   (32'sd0),
    .sum_o (prod_q88)
  );

  q88_sat_add u_accum (
    .a_i   (acc_ext),
    .b_i   (prod_q88_ext),
    .sum_o (acc_sum)
  );

  // Next-state and datapath update; clear wins over everything and aborts.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;

    if (wrAddr == CMD_CLR) begin
      acc_d   = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (wrAddr == CMD_LOAD) begin
            op_a_d  = A;
            op_b_d  = B;
            state_d = ST_MUL;
          end
        end
        ST_MUL: begin
          prod_d  = prod_full;
          state_d = ST_ACC;
        end
        ST_ACC: begin
          acc_d   = acc_sum;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all registers here are plain flops (no memory array), so every one is reset.
    if (!reset) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

  assign result = acc_q;

endmodule : nopipe_mac

// File: tb/tb_nopipe_mac.sv
// Directed self-checking bench for nopipe_mac with hand-computed Q8.8 values.
module tb_nopipe_mac;

  logic        clk;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  wrAddr;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  nopipe_mac dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .wrAddr (wrAddr),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, pass the rising edge, settle 1 time unit.
  task automatic cyc(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b);
    wrAddr = cmd;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
  endtask

  // Load, then check result stays old at N+1 and takes the new value at N+2.
  task automatic mac(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] prev, input logic [15:0] exp);
    cyc(4'd1, a, b);
    cyc(4'd0, 16'h0, 16'h0);
    check({tag, "_n1"}, result, prev);
    cyc(4'd0, 16'h0, 16'h0);
    check({tag, "_n2"}, result, exp);
  endtask

  // Dot-product vectors and hand-computed running sums.
  logic [15:0] dp_a   [10] = '{16'h0140, 16'h0280, 16'h0280, 16'h0200, 16'h0300,
                               16'h0200, 16'h0140, 16'h0380, 16'h0480, 16'h0200};
  logic [15:0] dp_b   [10] = '{16'h0180, 16'h0180, 16'h0500, 16'h0200, 16'h0500,
                               16'h0300, 16'h0380, 16'h0500, 16'h0400, 16'h0300};
  logic [15:0] dp_sum [10] = '{16'h01E0, 16'h05A0, 16'h1220, 16'h1620, 16'h2520,
                               16'h2B20, 16'h2F80, 16'h4100, 16'h5300, 16'h5900};

  initial begin
    logic [15:0] prev;

    // Reset with random inputs for 3 cycles.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wrAddr = 4'($urandom_range(0, 15));
      A      = 16'($urandom);
      B      = 16'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", result, 16'h0000);
    end
    wrAddr = 4'd0;
    @(negedge clk);
    reset = 1'b1;

    // Single MAC: 1.25 * 1.5 = 1.875.
    cyc(4'd2, 16'h0, 16'h0);
    check("clear0", result, 16'h0000);
    mac("single", 16'h0140, 16'h0180, 16'h0000, 16'h01E0);

    // Dot product, one load every 6 cycles.
    cyc(4'd2, 16'h0, 16'h0);
    prev = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      mac($sformatf("dot%0d", i), dp_a[i], dp_b[i], prev, dp_sum[i]);
      for (int k = 0; k < 3; k++) cyc(4'd0, 16'h0, 16'h0);
      prev = dp_sum[i];
    end
    check("dot_final", result, 16'h5900);

    // Signed: -1 * 2 = -2.
    cyc(4'd2, 16'h0, 16'h0);
    mac("signed", 16'hFF00, 16'h0200, 16'h0000, 16'hFE00);

    // Saturation, positive then sticky, then negative.
    cyc(4'd2, 16'h0, 16'h0);
    mac("sat_pos", 16'h7F00, 16'h7F00, 16'h0000, 16'h7FFF);
    mac("sat_pos2", 16'h7F00, 16'h7F00, 16'h7FFF, 16'h7FFF);
    cyc(4'd2, 16'h0, 16'h0);
    mac("sat_neg", 16'h8000, 16'h7F00, 16'h0000, 16'h8000);

    // Load held through MUL is ignored: exactly one 1.0 * 1.0 accumulation.
    cyc(4'd2, 16'h0, 16'h0);
    cyc(4'd1, 16'h0100, 16'h0100);
    cyc(4'd1, 16'h0300, 16'h0300);
    cyc(4'd0, 16'h0, 16'h0);
    check("busy_n2", result, 16'h0100);
    for (int k = 0; k < 4; k++) cyc(4'd0, 16'h0, 16'h0);
    check("busy_after", result, 16'h0100);

    // Clear during MUL aborts: result 0, nothing added later.
    cyc(4'd1, 16'h0100, 16'h0100);
    cyc(4'd2, 16'h0, 16'h0);
    check("abort_clr", result, 16'h0000);
    for (int k = 0; k < 4; k++) cyc(4'd0, 16'h0, 16'h0);
    check("abort_after", result, 16'h0000);

    // Reset dropped during ACC clears asynchronously and discards the MAC.
    mac("pre_rst", 16'h0100, 16'h0200, 16'h0000, 16'h0200);
    cyc(4'd1, 16'h0100, 16'h0100);
    cyc(4'd0, 16'h0, 16'h0);
    reset = 1'b0;
    #1;
    check("rst_acc_async", result, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cyc(4'd0, 16'h0, 16'h0);
    check("rst_acc_after", result, 16'h0000);
    mac("post_rst", 16'h0140, 16'h0180, 16'h0000, 16'h01E0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_nopipe_mac
